// File: rtl/alu_rs.sv
// Reservation station in front of the combinational ALU: holds issued ops until
// both operands are known, snoops the ALU and LSB CDBs, dispatches one ready op per cycle.
module alu_rs #(
    parameter int unsigned RS_SIZE = 16,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned INST_W  = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clr_in,
    input  logic              iss_valid,
    input  logic [INST_W-1:0] iss_inst,
    input  logic [31:0]       iss_npc,
    input  logic [31:0]       iss_imme,
    input  logic [31:0]       iss_rs1_val,
    input  logic [31:0]       iss_rs2_val,
    input  logic [TAG_W-1:0]  iss_rs1_tag,
    input  logic [TAG_W-1:0]  iss_rs2_tag,
    input  logic [TAG_W-1:0]  iss_dest_tag,
    output logic              rs_full,
    input  logic [TAG_W-1:0]  alu_cdb_tag,
    input  logic [31:0]       alu_cdb_val,
    input  logic [TAG_W-1:0]  lsb_cdb_tag,
    input  logic [31:0]       lsb_cdb_val,
    output logic [INST_W-1:0] up_inst,
    output logic [31:0]       up_npc,
    output logic [31:0]       up_rs1_val,
    output logic [31:0]       up_rs2_val,
    output logic [31:0]       up_imme,
    output logic [TAG_W-1:0]  up_tag_bus
);

    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy;
    logic [INST_W-1:0]  inst_q [RS_SIZE];
    logic [31:0]        npc_q  [RS_SIZE];
    logic [31:0]        imme_q [RS_SIZE];
    logic [TAG_W-1:0]   dest_q [RS_SIZE];
    logic [31:0]        val1_q [RS_SIZE];
    logic [31:0]        val2_q [RS_SIZE];
    logic [TAG_W-1:0]   tag1_q [RS_SIZE];
    logic [TAG_W-1:0]   tag2_q [RS_SIZE];

    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               ready_found;
    logic [IDX_W-1:0]   ready_idx;
    logic [31:0]        iss_v1;
    logic [31:0]        iss_v2;
    logic [TAG_W-1:0]   iss_t1;
    logic [TAG_W-1:0]   iss_t2;

    assign rs_full = &busy;

    // Lowest-index free slot and lowest-index ready entry, both from registered state.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy[i] && tag1_q[i] == '0 && tag2_q[i] == '0) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
        end
    end

    // Issue-cycle forwarding; ALU CDB takes precedence over LSB CDB on equal tags.
    always_comb begin
        iss_v1 = iss_rs1_val;
        iss_t1 = iss_rs1_tag;
        if (iss_rs1_tag != '0 && iss_rs1_tag == alu_cdb_tag) begin
            iss_v1 = alu_cdb_val;
            iss_t1 = '0;
        end else if (iss_rs1_tag != '0 && iss_rs1_tag == lsb_cdb_tag) begin
            iss_v1 = lsb_cdb_val;
            iss_t1 = '0;
        end
        iss_v2 = iss_rs2_val;
        iss_t2 = iss_rs2_tag;
        if (iss_rs2_tag != '0 && iss_rs2_tag == alu_cdb_tag) begin
            iss_v2 = alu_cdb_val;
            iss_t2 = '0;
        end else if (iss_rs2_tag != '0 && iss_rs2_tag == lsb_cdb_tag) begin
            iss_v2 = lsb_cdb_val;
            iss_t2 = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy       <= '0;
            up_inst    <= '0;
            up_npc     <= '0;
            up_rs1_val <= '0;
            up_rs2_val <= '0;
            up_imme    <= '0;
            up_tag_bus <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clr_in) begin
                busy       <= '0;
                up_inst    <= '0;
                up_npc     <= '0;
                up_rs1_val <= '0;
                up_rs2_val <= '0;
                up_imme    <= '0;
                up_tag_bus <= '0;
            end else begin
                // Snoop both CDBs for every waiting operand.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        if (tag1_q[i] != '0 && tag1_q[i] == alu_cdb_tag) begin
                            val1_q[i] <= alu_cdb_val;
                            tag1_q[i] <= '0;
                        end else if (tag1_q[i] != '0 && tag1_q[i] == lsb_cdb_tag) begin
                            val1_q[i] <= lsb_cdb_val;
                            tag1_q[i] <= '0;
                        end
                        if (tag2_q[i] != '0 && tag2_q[i] == alu_cdb_tag) begin
                            val2_q[i] <= alu_cdb_val;
                            tag2_q[i] <= '0;
                        end else if (tag2_q[i] != '0 && tag2_q[i] == lsb_cdb_tag) begin
                            val2_q[i] <= lsb_cdb_val;
                            tag2_q[i] <= '0;
                        end
                    end
                end

                if (ready_found) begin
                    up_inst         <= inst_q[ready_idx];
                    up_npc          <= npc_q[ready_idx];
                    up_rs1_val      <= val1_q[ready_idx];
                    up_rs2_val      <= val2_q[ready_idx];
                    up_imme         <= imme_q[ready_idx];
                    up_tag_bus      <= dest_q[ready_idx];
                    busy[ready_idx] <= 1'b0;
                end else begin
                    up_inst    <= '0;
                    up_npc     <= '0;
                    up_rs1_val <= '0;
                    up_rs2_val <= '0;
                    up_imme    <= '0;
                    up_tag_bus <= '0;
                end

                // free_idx is never busy, so it cannot collide with wakeup or dispatch.
                if (iss_valid && free_found) begin
                    busy[free_idx]   <= 1'b1;
                    inst_q[free_idx] <= iss_inst;
                    npc_q[free_idx]  <= iss_npc;
                    imme_q[free_idx] <= iss_imme;
                    dest_q[free_idx] <= iss_dest_tag;
                    val1_q[free_idx] <= iss_v1;
                    tag1_q[free_idx] <= iss_t1;
                    val2_q[free_idx] <= iss_v2;
                    tag2_q[free_idx] <= iss_t2;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: reset, ready issue, wakeup, issue forwarding,
// fill/order, back-to-back, flush and freeze.
module tb_alu_rs;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clr_in;
    logic        iss_valid;
    logic [5:0]  iss_inst;
    logic [31:0] iss_npc, iss_imme, iss_rs1_val, iss_rs2_val;
    logic [4:0]  iss_rs1_tag, iss_rs2_tag, iss_dest_tag;
    logic        rs_full;
    logic [4:0]  alu_cdb_tag, lsb_cdb_tag;
    logic [31:0] alu_cdb_val, lsb_cdb_val;
    logic [5:0]  up_inst;
    logic [31:0] up_npc, up_rs1_val, up_rs2_val, up_imme;
    logic [4:0]  up_tag_bus;

    int vectors = 0;
    int miscompares = 0;

    alu_rs #(.RS_SIZE(16), .TAG_W(5), .INST_W(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .iss_valid(iss_valid), .iss_inst(iss_inst), .iss_npc(iss_npc), .iss_imme(iss_imme),
        .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
        .iss_rs1_tag(iss_rs1_tag), .iss_rs2_tag(iss_rs2_tag), .iss_dest_tag(iss_dest_tag),
        .rs_full(rs_full),
        .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
        .up_inst(up_inst), .up_npc(up_npc), .up_rs1_val(up_rs1_val), .up_rs2_val(up_rs2_val),
        .up_imme(up_imme), .up_tag_bus(up_tag_bus)
    );

    always #5 clk_in = ~clk_in;

    // Advance one edge; outputs are sampled 1ns after it and inputs changed there too.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_inst = '0; iss_npc = '0; iss_imme = '0;
        iss_rs1_val = '0; iss_rs2_val = '0; iss_rs1_tag = '0; iss_rs2_tag = '0;
        iss_dest_tag = '0;
        alu_cdb_tag = '0; alu_cdb_val = '0; lsb_cdb_tag = '0; lsb_cdb_val = '0;
    endtask

    task automatic set_issue(input logic [5:0] inst, input logic [31:0] npc,
                             input logic [31:0] v1, input logic [4:0] t1,
                             input logic [31:0] v2, input logic [4:0] t2,
                             input logic [31:0] imm, input logic [4:0] dest);
        iss_valid = 1'b1; iss_inst = inst; iss_npc = npc;
        iss_rs1_val = v1; iss_rs1_tag = t1; iss_rs2_val = v2; iss_rs2_tag = t2;
        iss_imme = imm; iss_dest_tag = dest;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0;
        idle_inputs();
        step(); step();
        rst_in = 1'b0;
        vectors++; if (up_tag_bus !== 5'd0) begin miscompares++; $display("FAIL reset_tag got %0h exp 0", up_tag_bus); end
        vectors++; if (rs_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %0b exp 0", rs_full); end
        vectors++; if ({up_inst, up_npc, up_rs1_val, up_rs2_val, up_imme} !== '0) begin
            miscompares++; $display("FAIL reset_up got %0h/%0h/%0h/%0h/%0h exp all 0",
                                    up_inst, up_npc, up_rs1_val, up_rs2_val, up_imme); end
    endtask

    task automatic test_ready_issue();
        set_issue(6'd10, 32'h104, 32'd5, 5'd0, 32'd0, 5'd0, 32'd7, 5'd3);
        step();
        idle_inputs();
        vectors++; if (up_tag_bus !== 5'd0) begin miscompares++; $display("FAIL ready_latency got %0h exp 0", up_tag_bus); end
        step();
        vectors++; if (up_tag_bus !== 5'd3) begin miscompares++; $display("FAIL ready_tag got %0h exp 3", up_tag_bus); end
        vectors++; if (up_rs1_val !== 32'd5) begin miscompares++; $display("FAIL ready_rs1 got %0h exp 5", up_rs1_val); end
        vectors++; if (up_imme !== 32'd7) begin miscompares++; $display("FAIL ready_imme got %0h exp 7", up_imme); end
        vectors++; if (up_inst !== 6'd10 || up_npc !== 32'h104) begin
            miscompares++; $display("FAIL ready_inst_npc got %0h/%0h exp a/104", up_inst, up_npc); end
        step();
        vectors++; if (up_tag_bus !== 5'd0 || up_rs1_val !== 32'd0) begin
            miscompares++; $display("FAIL ready_freed got %0h/%0h exp 0/0", up_tag_bus, up_rs1_val); end
    endtask

    task automatic test_wakeup();
        set_issue(6'd1, 32'h200, 32'd0, 5'd4, 32'd10, 5'd0, 32'd0, 5'd6);
        step();
        idle_inputs();
        step();
        vectors++; if (up_tag_bus !== 5'd0) begin miscompares++; $display("FAIL wake_wait got %0h exp 0", up_tag_bus); end
        alu_cdb_tag = 5'd4; alu_cdb_val = 32'h20;
        step();
        idle_inputs();
        vectors++; if (up_tag_bus !== 5'd0) begin miscompares++; $display("FAIL wake_same_edge got %0h exp 0", up_tag_bus); end
        step();
        vectors++; if (up_tag_bus !== 5'd6) begin miscompares++; $display("FAIL wake_tag got %0h exp 6", up_tag_bus); end
        vectors++; if (up_rs1_val !== 32'h20 || up_rs2_val !== 32'd10) begin
            miscompares++; $display("FAIL wake_vals got %0h/%0h exp 20/a", up_rs1_val, up_rs2_val); end
    endtask

    task automatic test_issue_forward();
        set_issue(6'd2, 32'h300, 32'd1, 5'd0, 32'd0, 5'd9, 32'd0, 5'd11);
        lsb_cdb_tag = 5'd9; lsb_cdb_val = 32'hABCD;
        step();
        idle_inputs();
        step();
        vectors++; if (up_tag_bus !== 5'd11 || up_rs2_val !== 32'hABCD) begin
            miscompares++; $display("FAIL fwd_lsb got tag %0h val %0h exp b/abcd", up_tag_bus, up_rs2_val); end
        set_issue(6'd2, 32'h304, 32'd0, 5'd9, 32'd3, 5'd0, 32'd0, 5'd12);
        alu_cdb_tag = 5'd9; alu_cdb_val = 32'd1;
        lsb_cdb_tag = 5'd9; lsb_cdb_val = 32'd2;
        step();
        idle_inputs();
        step();
        vectors++; if (up_tag_bus !== 5'd12 || up_rs1_val !== 32'd1) begin
            miscompares++; $display("FAIL fwd_alu_wins got tag %0h val %0h exp c/1", up_tag_bus, up_rs1_val); end
        step();
    endtask

    task automatic test_fill_order();
        for (int i = 0; i < 16; i++) begin
            set_issue(6'd3, 32'(i * 4), 32'd0, 5'd7, 32'd2, 5'd0, 32'(i), 5'(i + 8));
            step();
        end
        idle_inputs();
        vectors++; if (rs_full !== 1'b1) begin miscompares++; $display("FAIL fill_full got %0b exp 1", rs_full); end
        alu_cdb_tag = 5'd7; alu_cdb_val = 32'h77;
        step();
        idle_inputs();
        vectors++; if (rs_full !== 1'b1 || up_tag_bus !== 5'd0) begin
            miscompares++; $display("FAIL fill_woken got full %0b tag %0h exp 1/0", rs_full, up_tag_bus); end
        for (int i = 0; i < 16; i++) begin
            step();
            vectors++; if (up_tag_bus !== 5'(i + 8) || up_rs1_val !== 32'h77 || up_imme !== 32'(i)) begin
                miscompares++; $display("FAIL fill_order[%0d] got tag %0h val %0h imm %0h exp %0h/77/%0h",
                                        i, up_tag_bus, up_rs1_val, up_imme, i + 8, i); end
            if (i == 0) begin
                vectors++; if (rs_full !== 1'b0) begin miscompares++; $display("FAIL fill_drop got %0b exp 0", rs_full); end
            end
        end
        step();
        vectors++; if (up_tag_bus !== 5'd0) begin miscompares++; $display("FAIL fill_empty got %0h exp 0", up_tag_bus); end
    endtask

    task automatic test_back_to_back();
        set_issue(6'd4, 32'h400, 32'd100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1);
        step();
        set_issue(6'd5, 32'h404, 32'd200, 5'd0, 32'd0, 5'd0, 32'd0, 5'd2);
        step();
        idle_inputs();
        vectors++; if (up_tag_bus !== 5'd1 || up_rs1_val !== 32'd100) begin
            miscompares++; $display("FAIL b2b_first got %0h/%0h exp 1/64", up_tag_bus, up_rs1_val); end
        step();
        vectors++; if (up_tag_bus !== 5'd2 || up_rs1_val !== 32'd200 || up_inst !== 6'd5) begin
            miscompares++; $display("FAIL b2b_second got %0h/%0h/%0h exp 2/c8/5", up_tag_bus, up_rs1_val, up_inst); end
        step();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_issue(6'd6, 32'h500, 32'd0, 5'd5, 32'd0, 5'd0, 32'd0, 5'(20 + i));
            step();
        end
        set_issue(6'd6, 32'h50c, 32'd9, 5'd0, 32'd0, 5'd0, 32'd0, 5'd25);
        clr_in = 1'b1;
        step();
        clr_in = 1'b0;
        idle_inputs();
        vectors++; if (up_tag_bus !== 5'd0 || rs_full !== 1'b0) begin
            miscompares++; $display("FAIL flush_now got tag %0h full %0b exp 0/0", up_tag_bus, rs_full); end
        alu_cdb_tag = 5'd5; alu_cdb_val = 32'h55;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (up_tag_bus !== 5'd0) begin
                miscompares++; $display("FAIL flush_after[%0d] got %0h exp 0", i, up_tag_bus); end
        end
    endtask

    task automatic test_freeze();
        set_issue(6'd7, 32'h600, 32'h55, 5'd0, 32'd0, 5'd0, 32'd0, 5'd13);
        step();
        idle_inputs();
        step();
        vectors++; if (up_tag_bus !== 5'd13) begin miscompares++; $display("FAIL freeze_pre got %0h exp d", up_tag_bus); end
        rdy_in = 1'b0;
        set_issue(6'd7, 32'h604, 32'h66, 5'd0, 32'd0, 5'd0, 32'd0, 5'd14);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (up_tag_bus !== 5'd13 || up_rs1_val !== 32'h55) begin
                miscompares++; $display("FAIL freeze_hold[%0d] got %0h/%0h exp d/55", i, up_tag_bus, up_rs1_val); end
        end
        rdy_in = 1'b1;
        idle_inputs();
        step();
        vectors++; if (up_tag_bus !== 5'd0) begin miscompares++; $display("FAIL freeze_once got %0h exp 0", up_tag_bus); end
        // Stall between issue and dispatch: the op must come out once rdy_in returns.
        set_issue(6'd8, 32'h700, 32'h99, 5'd0, 32'd0, 5'd0, 32'd0, 5'd15);
        step();
        idle_inputs();
        rdy_in = 1'b0;
        step(); step();
        vectors++; if (up_tag_bus !== 5'd0) begin miscompares++; $display("FAIL freeze_pending got %0h exp 0", up_tag_bus); end
        rdy_in = 1'b1;
        step();
        vectors++; if (up_tag_bus !== 5'd15 || up_rs1_val !== 32'h99) begin
            miscompares++; $display("FAIL freeze_resume got %0h/%0h exp f/99", up_tag_bus, up_rs1_val); end
        step();
        vectors++; if (up_tag_bus !== 5'd0) begin miscompares++; $display("FAIL freeze_single got %0h exp 0", up_tag_bus); end
    endtask

    initial begin
        test_reset();
        test_ready_issue();
        test_wakeup();
        test_issue_forward();
        test_fill_order();
        test_back_to_back();
        test_flush();
        test_freeze();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station feeding the combinational ALU: buffers issued arithmetic/branch/jump ops and waits for operands.
- Snoops the two CDBs (ALU result, LSB result) to capture pending operands.
- Each cycle, dispatches at most one ready entry on registered outputs that drive the ALU's up_* inputs.
- Sits between the issue/decode stage and the ALU; the ALU result returns on the ALU CDB, which this block also snoops.

Parameters:
- RS_SIZE, 16, number of entries (power of 2)
- TAG_W, 5, ROB tag width; tag 0 is reserved as "no instruction / operand ready"
- INST_W, 6, internal instruction-code width (same encoding the ALU decodes)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; when low the block freezes
- clr_in  in  1  ROB flush (misprediction); discards all entries
- iss_valid  in  1  issue request this cycle
- iss_inst  in  INST_W  instruction code
- iss_npc  in  32  PC+4 of instruction
- iss_imme  in  32  sign/zero-extended immediate
- iss_rs1_val, iss_rs2_val  in  32 each  operand values (valid when tag==0)
- iss_rs1_tag, iss_rs2_tag  in  TAG_W each  producer ROB tag, 0 = value ready
- iss_dest_tag  in  TAG_W  ROB tag of this instruction (nonzero)
- rs_full  out  1  no free entry
- alu_cdb_tag  in  TAG_W  ALU broadcast tag (0 = none)
- alu_cdb_val  in  32  ALU broadcast value
- lsb_cdb_tag  in  TAG_W  LSB broadcast tag (0 = none)
- lsb_cdb_val  in  32  LSB broadcast value
- up_inst  out  INST_W  dispatched instruction
- up_npc  out  32
- up_rs1_val, up_rs2_val  out  32 each
- up_imme  out  32
- up_tag_bus  out  TAG_W  dispatched ROB tag; 0 = no dispatch this cycle

Behaviour:
- Reset (rst_in=1 at posedge): all entries invalid; all up_* outputs = 0; rs_full = 0 after reset.
  - Priority: rst_in > rdy_in low > clr_in > normal.
- rdy_in=0: no state change. Issue is ignored and up_* registers hold. The ALU gates on rdy_in, so a held dispatch executes exactly once when rdy_in returns.
- clr_in=1 (rdy_in=1): all entries invalid and up_tag_bus=0 at the next edge. A concurrent issue is dropped.
- Entry state: busy, inst, npc, imme, dest, val1/tag1, val2/tag2. An operand is ready iff its tag == 0.
- rs_full:
  - Combinational; asserted iff all RS_SIZE entries are busy.
  - Does not credit a same-cycle dispatch.
  - Issue while rs_full=1 is a protocol violation; the bench must never drive it.
- Issue:
  - Allocates the lowest-index non-busy entry.
  - Per operand, the tag is checked against both CDBs in the issue cycle. On a match (nonzero tag), the CDB value is stored and the tag set to 0; otherwise the iss_* value/tag is stored.
  - If both CDBs carry the same tag, the ALU CDB wins.
- Wakeup: each cycle, every busy entry with operand tag T≠0 equal to alu_cdb_tag or lsb_cdb_tag captures that value and clears its tag.
- Dispatch:
  - Select the lowest-index busy entry whose registered tag1==0 and tag2==0 (state before this edge).
  - Copy its fields to up_* at the edge and free the entry at the same edge.
  - If none is ready, up_tag_bus=0 and the other up_* outputs = 0.
- Latency: issue with both operands ready → up_tag_bus valid at edge N+1 → ALU result on CDB during cycle N+1.
  - An entry woken at edge N dispatches at edge N+1 at earliest; there is no same-edge wake-and-dispatch.
- A freed slot is reusable for issue in the following cycle, not the same edge.
- Throughput: 1 dispatch/cycle, 1 issue/cycle; issue and dispatch may touch different entries at the same edge.
- Branch, jal, jalr, lui and auipc pass through unchanged; immediate-only ops issue with rs2_tag=0.

Test Plan:
- Reset then idle: rst_in=1 for 2 cycles → up_tag_bus=0, rs_full=0, all up_* 0.
- Ready issue: addi, rs1_val=5, imme=7, tags 0, dest=3 at edge N → at edge N+1, up_tag_bus=3, up_rs1_val=5, up_imme=7; entry freed.
- Wakeup: add, rs1_tag=4, rs2_val=10, dest=6; two cycles later alu_cdb_tag=4, val=0x20 → up_tag_bus=6, up_rs1_val=0x20 one edge after capture.
- Issue-cycle forwarding: issue with rs2_tag=9 while lsb_cdb_tag=9, val=0xABCD → dispatched next edge with up_rs2_val=0xABCD. Also drive alu and lsb both tag 9 (values 1/2) → captured value 1.
- Fill and order: issue 16 ops all waiting on tag 7 → rs_full=1. Broadcast tag 7 → dispatch in index order 0..15 on consecutive cycles; rs_full drops after the first dispatch.
- Flush and freeze: with 3 pending entries, pulse clr_in → up_tag_bus=0 thereafter and rs_full=0. Hold rdy_in=0 during a pending dispatch → up_* frozen; single dispatch completes after rdy_in returns.
